// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding imem request,
// one-entry output holding register, redirect handling and flush pulse.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PC_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic        flush_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] ipc_q;
    logic        valid_q;
    logic        flush_q;
    logic [31:0] cnt_q;
    logic        pend_q;
    logic [31:0] pend_tgt_q;
    logic        req_c;

    logic [31:0] tgt;
    logic        in_req;
    logic        in_hold;
    logic        ack_req;
    logic        br_acc;
    logic        xfer;
    logic        deliver;
    logic        redir_ack;
    logic        unused_tgt_bits;

    assign unused_tgt_bits = ^branch_target_i[1:0];

    assign tgt       = {branch_target_i[31:2], 2'b00};
    assign in_req    = (state_q == REQ);
    assign in_hold   = (state_q == HOLD);
    assign ack_req   = in_req & imem_ack_i;
    assign br_acc    = branch_i & (in_req | in_hold);
    assign xfer      = in_hold & valid_q & instr_ready_i & ~branch_i;
    // A redirect seen before or with the ack turns the ack into a discard
    assign deliver   = ack_req & ~pend_q & ~branch_i;
    assign redir_ack = ack_req & (pend_q | branch_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = REQ;
            end
            REQ: begin
                if (deliver) state_d = HOLD;
            end
            HOLD: begin
                if (branch_i) begin
                    state_d = REQ;
                end else if (xfer) begin
                    state_d = start_i ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_c = 1'b0;
        if (state_q == REQ) req_c = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            ipc_q      <= 32'h0;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
            cnt_q      <= 32'h0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
        end else begin
            flush_q <= br_acc;

            if (deliver) begin
                pc_q <= pc_q + STEP;
            end else if (redir_ack) begin
                pc_q <= branch_i ? tgt : pend_tgt_q;
            end else if (in_hold & branch_i) begin
                pc_q <= tgt;
            end

            // Request address must stay put until ack, so park the target
            if (in_req & branch_i & ~imem_ack_i) begin
                pend_q     <= 1'b1;
                pend_tgt_q <= tgt;
            end else if (ack_req) begin
                pend_q     <= 1'b0;
            end

            if (deliver) begin
                instr_q <= imem_rdata_i;
                ipc_q   <= pc_q;
                valid_q <= 1'b1;
            end else if (in_hold & (branch_i | xfer)) begin
                valid_q <= 1'b0;
            end

            if (xfer) cnt_q <= cnt_q + 32'd1;
        end
    end

    assign imem_req_o    = req_c;
    assign imem_addr_o   = pc_q;
    assign PC_o          = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign instr_valid_o = valid_q;
    assign flush_o       = flush_q;
    assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a memory model answers requests,
// a scoreboard monitor checks each delivered instruction in order.
module tb_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        branch;
    logic [31:0] branch_tgt;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        ready;
    logic        flush;
    logic [31:0] fetch_cnt;

    int   n_tests;
    int   n_fail;
    int   lat;
    int   mcnt;
    int   nflush;
    logic inj;
    exp_t sb[$];
    exp_t e;

    fetch_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .start_i        (start),
        .branch_i       (branch),
        .branch_target_i(branch_tgt),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ack_i     (imem_ack),
        .imem_rdata_i   (imem_rdata),
        .PC_o           (pc),
        .instr_o        (instr),
        .instr_pc_o     (instr_pc),
        .instr_valid_o  (instr_valid),
        .instr_ready_i  (ready),
        .flush_o        (flush),
        .fetch_cnt_o    (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return ~a ^ 32'h3C00_0000;
    endfunction

    // Memory: ack after `lat` request cycles, or on demand via inj
    always @(negedge clk) begin
        imem_ack = 1'b0;
        if (!rst_n) begin
            mcnt = 0;
        end else if (inj) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req) begin
            mcnt++;
            if (mcnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = memw(imem_addr);
                mcnt       = 0;
            end
        end else begin
            mcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (flush) nflush++;
    end

    always @(negedge clk) begin
        if (rst_n && instr_valid && ready && !branch) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL deliver: got pc %h, none expected",
                         instr_pc);
            end else begin
                e = sb.pop_front();
                if (instr_pc !== e.pc || instr !== e.ins) begin
                    n_fail++;
                    $display("FAIL deliver: got %h/%h expected %h/%h",
                             instr_pc, instr, e.pc, e.ins);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        sb.push_back({a, memw(a)});
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        branch     = 1'b0;
        branch_tgt = 32'h0;
        ready      = 1'b1;
        inj        = 1'b0;
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_cnt(input logic [31:0] v, output int k);
        k = 0;
        while (fetch_cnt !== v && k < 40) begin
            tick();
            k++;
        end
        check("wait_cnt", fetch_cnt, v);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((imem_req || instr_valid) && k < 40) begin
            tick();
            k++;
        end
        check("idle", {30'b0, imem_req, instr_valid}, 32'h0);
        check("sb_empty", sb.size(), 32'h0);
    endtask

    initial begin
        int k;
        int f0;
        n_tests  = 0;
        n_fail   = 0;
        nflush   = 0;
        lat      = 1;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;

        // Reset values and sequential stream at 2 cycles per instruction
        do_reset();
        check("rst_pc", pc, 32'h0);
        check("rst_ctl", {28'b0, imem_req, instr_valid, flush, 1'b0},
              32'h0);
        check("rst_cnt", fetch_cnt, 32'h0);
        check("rst_ins", instr, 32'h0);
        check("rst_ipc", instr_pc, 32'h0);
        push(32'h0);
        push(32'h4);
        push(32'h8);
        push(32'hC);
        start = 1'b1;
        wait_cnt(32'd3, k);
        check("rate_edges", k, 32'd7);
        start = 1'b0;
        wait_idle();
        check("stop_cnt", fetch_cnt, 32'd4);
        check("stop_pc", pc, 32'h10);

        // Decode stall holds the second instruction
        do_reset();
        push(32'h0);
        push(32'h4);
        start = 1'b1;
        wait_cnt(32'd1, k);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc", instr_pc, 32'h4);
            check("stall_ins", instr, memw(32'h4));
            check("stall_ctl", {30'b0, instr_valid, imem_req}, 32'h2);
            check("stall_cnt", fetch_cnt, 32'd1);
        end
        ready = 1'b1;
        start = 1'b0;
        wait_idle();
        check("stall_end_cnt", fetch_cnt, 32'd2);

        // Redirect one cycle before ack, then two back-to-back branches
        do_reset();
        lat = 2;
        push(32'h0);
        push(32'h4);
        push(32'h308);
        start = 1'b1;
        wait_cnt(32'd2, k);
        f0 = nflush;
        branch = 1'b1;
        branch_tgt = 32'h103;
        tick();
        branch = 1'b0;
        check("pend_pc", pc, 32'h8);
        check("pend_flush", flush, 1'b1);
        check("pend_req", imem_req, 1'b1);
        tick();
        check("redir_pc", pc, 32'h100);
        check("redir_flush", flush, 1'b0);
        check("redir_valid", instr_valid, 1'b0);
        check("flush_once", nflush - f0, 32'd1);
        branch = 1'b1;
        branch_tgt = 32'h204;
        tick();
        branch_tgt = 32'h30B;
        check("pend2_pc", pc, 32'h100);
        tick();
        branch = 1'b0;
        start = 1'b0;
        check("last_wins_pc", pc, 32'h308);
        check("ack_br_flush", flush, 1'b1);
        wait_idle();
        check("redir_cnt", fetch_cnt, 32'd3);
        check("redir_end_pc", pc, 32'h30C);
        check("flush_total", nflush - f0, 32'd3);

        // Branch coincident with a HOLD transfer
        do_reset();
        lat = 1;
        push(32'h0);
        push(32'h200);
        start = 1'b1;
        wait_cnt(32'd1, k);
        tick();
        check("hold_valid", instr_valid, 1'b1);
        branch = 1'b1;
        branch_tgt = 32'h200;
        tick();
        branch = 1'b0;
        start = 1'b0;
        check("hbr_cnt", fetch_cnt, 32'd1);
        check("hbr_valid", instr_valid, 1'b0);
        check("hbr_addr", imem_addr, 32'h200);
        check("hbr_req", imem_req, 1'b1);
        check("hbr_flush", flush, 1'b1);
        wait_idle();
        check("hbr_end_cnt", fetch_cnt, 32'd2);
        check("hbr_end_pc", pc, 32'h204);

        // PC and counter wrap
        do_reset();
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        push(32'h0);
        push(32'hFFFF_FFFC);
        start = 1'b1;
        wait_cnt(32'hFFFF_FFFF, k);
        tick();
        branch = 1'b1;
        branch_tgt = 32'hFFFF_FFFF;
        start = 1'b0;
        tick();
        branch = 1'b0;
        check("wrap_tgt", pc, 32'hFFFF_FFFC);
        check("wrap_cnt_hold", fetch_cnt, 32'hFFFF_FFFF);
        wait_idle();
        check("wrap_cnt", fetch_cnt, 32'h0);
        check("wrap_pc", pc, 32'h0);

        // Reset mid-request, late ack, branch while idle
        do_reset();
        lat = 3;
        start = 1'b1;
        tick();
        tick();
        check("mid_req", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_pc", pc, 32'h0);
        check("arst_ctl", {29'b0, imem_req, instr_valid, flush}, 32'h0);
        check("arst_cnt", fetch_cnt, 32'h0);
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        tick();
        check("late_ack_ctl", {30'b0, imem_req, instr_valid}, 32'h0);
        check("late_ack_pc", pc, 32'h0);
        check("late_ack_ins", instr, 32'h0);
        check("late_ack_cnt", fetch_cnt, 32'h0);
        branch = 1'b1;
        branch_tgt = 32'h40;
        tick();
        branch = 1'b0;
        check("idle_br_flush", flush, 1'b0);
        check("idle_br_pc", pc, 32'h0);
        check("idle_br_req", imem_req, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
